// File: rtl/rv32_muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiplier and restoring divider
// sharing one 64-bit accumulator, with a fixed 32-iteration latency for every op.
module rv32_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [2:0]  op;
    logic [31:0] b_reg;
    logic [63:0] acc;
    logic        neg_q, neg_r, b_zero;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] rem_sub;
    logic [63:0] div_next;
    logic [63:0] acc_next;
    logic [63:0] prod_s;
    logic [31:0] quo_s, rem_s;
    logic [31:0] final_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (count == 5'd31) state_next = FINISH;
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Divides treat funct3[0]=0 as signed; among multiplies only MULH/MULHSU sign op_a.
    always_comb begin
        a_signed = funct3[2] ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
        b_signed = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
        a_neg    = a_signed & op_a[31];
        b_neg    = b_signed & op_b[31];
        a_mag    = a_neg ? (~op_a + 32'd1) : op_a;
        b_mag    = b_neg ? (~op_b + 32'd1) : op_b;
    end

    // acc holds {high/remainder, low/multiplier-or-quotient}; both ops shift one bit per cycle.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_reg} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        rem_sh   = {acc[63:32], acc[31]};
        ge       = rem_sh >= {1'b0, b_reg};
        rem_sub  = rem_sh[31:0] - b_reg;
        div_next = {(ge ? rem_sub : rem_sh[31:0]), acc[30:0], ge};
        acc_next = op[2] ? div_next : mul_next;
    end

    // Divide by zero leaves quotient magnitude all-ones, but the sign fix-up must not touch it.
    always_comb begin
        prod_s = neg_q ? (~acc_next + 64'd1) : acc_next;
        quo_s  = b_zero ? 32'hFFFF_FFFF
                        : (neg_q ? (~acc_next[31:0] + 32'd1) : acc_next[31:0]);
        rem_s  = neg_r ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
        case (op)
            3'b000:                 final_result = prod_s[31:0];
            3'b001, 3'b010, 3'b011: final_result = prod_s[63:32];
            3'b100, 3'b101:         final_result = quo_s;
            default:                final_result = rem_s;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 5'd0;
            op     <= 3'd0;
            b_reg  <= 32'd0;
            acc    <= 64'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            result <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op     <= funct3;
                        b_reg  <= b_mag;
                        acc    <= {32'd0, a_mag};
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        b_zero <= (op_b == 32'd0);
                        count  <= 5'd0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) result <= final_result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Self-checking bench for rv32_muldiv_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_rv32_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_result = 32'd0;

    always #5 clk = ~clk;

    rv32_muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          qa, qb;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        qa  = a;
        qb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(qa / qb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(qa % qb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one op; optionally re-pulses start (with junk operands) before a given edge and in FINISH.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input int repulse_edge, input bit repulse_finish);
        logic [31:0] exp;
        exp = ref_model(f, a, b);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        checkOutput("busy_e0", {31'd0, busy}, 32'd1);
        checkOutput("result_held_e0", result, last_result);
        for (int k = 1; k <= 32; k++) begin
            if (k == repulse_edge) begin
                start  = 1'b1;
                funct3 = ~f;
                op_a   = $urandom;
                op_b   = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k < 32) begin
                checkOutput("busy_run", {31'd0, busy}, 32'd1);
                checkOutput("done_run", {31'd0, done}, 32'd0);
            end
            if (k == 31) checkOutput("result_held_run", result, last_result);
        end
        checkOutput("done_finish", {31'd0, done}, 32'd1);
        checkOutput("busy_finish", {31'd0, busy}, 32'd1);
        checkOutput($sformatf("result_f%0d_%h_%h", f, a, b), result, exp);
        if (repulse_finish) begin
            start  = 1'b1;
            funct3 = 3'($urandom);
            op_a   = $urandom;
            op_b   = $urandom;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("done_idle", {31'd0, done}, 32'd0);
        checkOutput("busy_idle", {31'd0, busy}, 32'd0);
        checkOutput("result_idle", result, exp);
        last_result = exp;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          sel;

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;

        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, -1, 1'b0);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, -1, 1'b0);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        applyStimulus(3'd5, 32'd100, 32'd0, -1, 1'b0);
        applyStimulus(3'd6, 32'd100, 32'd0, -1, 1'b0);
        applyStimulus(3'd4, 32'hFFFF_FF9C, 32'd0, -1, 1'b0);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);

        // Start re-pulsed at E5 and in FINISH must both be ignored.
        applyStimulus(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5, 1'b1);
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            checkOutput("no_second_done", {31'd0, done}, 32'd0);
            checkOutput("no_second_busy", {31'd0, busy}, 32'd0);
        end
        checkOutput("result_after_repulse", result, last_result);

        // Reset at E10 of a divide aborts it immediately.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd4;
        op_a   = $urandom;
        op_b   = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        last_result = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b0;
        applyStimulus(3'd0, 32'd3, 32'd4, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom);
            sel = $urandom_range(0, 4);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                1: b = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                4: b = 32'($signed(-$urandom_range(1, 50)));
                default: ;
            endcase
            applyStimulus(f, a, b, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
